// File: rtl/drp_pkg.sv
// rtl/drp_pkg.sv - shared DRP widths, FSM encoding, error data and address range check
package drp_pkg;

    localparam int DRP_ADDR_WIDTH = 16;
    localparam int DRP_DATA_WIDTH = 16;
    localparam logic [15:0] DRP_ERR_DATA = 16'hDEAD;

    typedef enum logic {
        DRP_IDLE = 1'b0,
        DRP_BUSY = 1'b1
    } drp_state_e;

    // Once addr >= base is known the subtraction cannot wrap, so the
    // 32-bit result matches an index taken at the native address width.
    function automatic logic drp_addr_in_range(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input logic [31:0] num);
        return (addr >= base) && ((addr - base) < num);
    endfunction

endpackage

// File: rtl/drp_rdy_delay.sv
// rtl/drp_rdy_delay.sv - loadable down-counter producing the single-cycle DRP RDY pulse
module drp_rdy_delay #(
    parameter int C_RDY_LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic active_i,
    output logic rdy_o
);

    localparam logic [3:0] LOAD_VAL = 4'(C_RDY_LATENCY - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (active_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rdy_o = active_i && (cnt_q == 4'd0);

endmodule

// File: rtl/drp_slave_regbank.sv
// rtl/drp_slave_regbank.sv - DRP responder register bank with fixed EN-to-RDY latency
module drp_slave_regbank
    import drp_pkg::*;
#(
    parameter int                          C_DRP_ADDR_WIDTH = DRP_ADDR_WIDTH,
    parameter int                          C_DRP_DATA_WIDTH = DRP_DATA_WIDTH,
    parameter logic [C_DRP_ADDR_WIDTH-1:0] C_BASE_ADDR      = '0,
    parameter int                          C_REG_NUM        = 16,
    parameter int                          C_RDY_LATENCY    = 3,
    parameter logic [C_DRP_DATA_WIDTH-1:0] C_ERR_DATA       = DRP_ERR_DATA
) (
    input  logic                                  DRPCLK_I,
    input  logic                                  DRPRST_I,
    input  logic [C_DRP_ADDR_WIDTH-1:0]           S_DRPADDR_I,
    input  logic [C_DRP_DATA_WIDTH-1:0]           S_DRPDI_I,
    input  logic                                  S_DRPEN_I,
    input  logic                                  S_DRPWE_I,
    output logic [C_DRP_DATA_WIDTH-1:0]           S_DRPDO_O,
    output logic                                  S_DRPRDY_O,
    output logic [C_REG_NUM*C_DRP_DATA_WIDTH-1:0] REG_FLAT_O,
    output logic [C_REG_NUM-1:0]                  REG_WR_PULSE_O,
    output logic                                  ERR_BUSY_O,
    output logic                                  ERR_RANGE_O,
    input  logic                                  ERR_CLR_I
);

    localparam int IDX_W = (C_REG_NUM > 1) ? $clog2(C_REG_NUM) : 1;

    drp_state_e                  state_q, state_d;
    logic [C_DRP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DRP_DATA_WIDTH-1:0] di_q, di_d;
    logic                        we_q, we_d;
    logic [C_DRP_DATA_WIDTH-1:0] regs_q [C_REG_NUM];
    logic [C_DRP_DATA_WIDTH-1:0] regs_d [C_REG_NUM];
    logic [C_REG_NUM-1:0]        wr_pulse_q, wr_pulse_d;
    logic                        err_busy_q, err_busy_d;
    logic                        err_range_q, err_range_d;

    logic             busy;
    logic             accept;
    logic             rdy;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign busy     = (state_q == DRP_BUSY);
    assign accept   = !busy && S_DRPEN_I;
    assign in_range = drp_addr_in_range(32'(addr_q), 32'(C_BASE_ADDR), 32'(C_REG_NUM));
    assign idx      = IDX_W'(addr_q - C_BASE_ADDR);

    drp_rdy_delay #(
        .C_RDY_LATENCY(C_RDY_LATENCY)
    ) u_rdy_delay (
        .clk      (DRPCLK_I),
        .rst      (DRPRST_I),
        .load_i   (accept),
        .active_i (busy),
        .rdy_o    (rdy)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        di_d        = di_q;
        we_d        = we_q;
        regs_d      = regs_q;
        wr_pulse_d  = '0;
        err_busy_d  = err_busy_q;
        err_range_d = err_range_q;

        case (state_q)
            DRP_IDLE: begin
                if (S_DRPEN_I) begin
                    state_d = DRP_BUSY;
                    addr_d  = S_DRPADDR_I;
                    di_d    = S_DRPDI_I;
                    we_d    = S_DRPWE_I;
                end
            end
            DRP_BUSY: begin
                if (rdy) begin
                    state_d = DRP_IDLE;
                end
            end
        endcase

        // Commit on the RDY edge so the pulse and new value appear together next cycle.
        if (rdy && we_q && in_range) begin
            regs_d[idx]     = di_q;
            wr_pulse_d[idx] = 1'b1;
        end

        if (busy && S_DRPEN_I) begin
            err_busy_d = 1'b1;
        end else if (ERR_CLR_I) begin
            err_busy_d = 1'b0;
        end

        if (rdy && !in_range) begin
            err_range_d = 1'b1;
        end else if (ERR_CLR_I) begin
            err_range_d = 1'b0;
        end
    end

    always_ff @(posedge DRPCLK_I) begin
        if (DRPRST_I) begin
            state_q     <= DRP_IDLE;
            addr_q      <= '0;
            di_q        <= '0;
            we_q        <= 1'b0;
            regs_q      <= '{default: '0};
            wr_pulse_q  <= '0;
            err_busy_q  <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            di_q        <= di_d;
            we_q        <= we_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            err_busy_q  <= err_busy_d;
            err_range_q <= err_range_d;
        end
    end

    always_comb begin
        S_DRPDO_O = '0;
        if (rdy && !we_q) begin
            S_DRPDO_O = in_range ? regs_q[idx] : C_ERR_DATA;
        end
    end

    for (genvar i = 0; i < C_REG_NUM; i++) begin : g_flat
        assign REG_FLAT_O[i*C_DRP_DATA_WIDTH +: C_DRP_DATA_WIDTH] = regs_q[i];
    end

    assign S_DRPRDY_O     = rdy;
    assign REG_WR_PULSE_O = wr_pulse_q;
    assign ERR_BUSY_O     = err_busy_q;
    assign ERR_RANGE_O    = err_range_q;

endmodule
